// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and helpers for the parallel-in/serial-out serialiser.
//   state_e    : serialiser FSM states (PARITY is only entered when the
//                PISO_PARITY_EN build macro is defined).
//   cnt_width  : bit-counter width for a given word width.
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // The counter only has to hold WIDTH-1, so $clog2(WIDTH) bits suffice.
  // The floor of 1 keeps the vector legal for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Loadable down-counter with a zero flag. It saturates at zero, so a decrement
// request at zero leaves the count unchanged.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   load        : load load_value (has priority over dec)
//   load_value  : value loaded on load
//   dec         : decrement by one when non-zero
//   zero        : count == 0
// -----------------------------------------------------------------------------
module bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order in which blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serialiser.sv
// -----------------------------------------------------------------------------
// piso_serialiser
// Parallel-in/serial-out shift register. A word is accepted through a
// valid/ready handshake and is then emitted one bit per clock edge on which
// shift_en is 1, MSB- or LSB-first. done pulses for one cycle after the final
// bit has been retired.
//
// Build option: define PISO_PARITY_EN to append one even-parity bit (the XOR
// of the accepted word) after the data bits. This delays done by one enabled
// edge.
//
// Parameters:
//   WIDTH      : word width, 2..32
//   MSB_FIRST  : 1 = bit WIDTH-1 first, 0 = bit 0 first
//   IDLE_LEVEL : ser_out level whenever no bit is being presented
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_valid : load_data is valid
//   load_ready : a word can be accepted (IDLE, and out of reset)
//   load_data  : parallel word to serialise
//   shift_en   : bit-rate tick; one bit is retired per edge where it is 1
//   ser_out    : serial data (registered)
//   ser_valid  : ser_out carries a data or parity bit (registered)
//   done       : one-cycle pulse after the final bit (registered)
// -----------------------------------------------------------------------------
module piso_serialiser
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_rot;
  logic             armed;
  logic             accept;
  logic             cnt_dec;
  logic             cnt_zero;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  // The bit at the output end of a word, given the shift direction.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Rotate rather than shift: the bits that wrap round are never presented
  // because the counter ends the word first, and every register bit stays live.
  assign sreg_rot = MSB_FIRST ? {sreg[WIDTH-2:0], sreg[WIDTH-1]}
                              : {sreg[0], sreg[WIDTH-1:1]};

  // armed holds ready low while reset is asserted and goes high on the first
  // edge after release.
  assign load_ready = armed && (state == IDLE);
  assign accept     = load_valid && load_ready;
  assign cnt_dec    = (state == SHIFT) && shift_en;

  bit_counter #(
    .W (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_value (CNT_W'(WIDTH - 1)),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      armed     <= 1'b0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg      <= load_data;
            ser_out   <= out_bit(load_data);
            ser_valid <= 1'b1;
            state     <= SHIFT;
`ifdef PISO_PARITY_EN
            parity_q  <= ^load_data;
`endif
          end
        end

        SHIFT: begin
          if (shift_en) begin
            if (!cnt_zero) begin
              sreg    <= sreg_rot;
              ser_out <= out_bit(sreg_rot);
            end else begin
`ifdef PISO_PARITY_EN
              ser_out   <= parity_q;
              state     <= PARITY;
`else
              ser_out   <= IDLE_LEVEL;
              ser_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
`endif
            end
          end
        end

`ifdef PISO_PARITY_EN
        PARITY: begin
          if (shift_en) begin
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
`endif

        // NOTE: an explicit default recovers any unused encoding to IDLE
        // instead of leaving the FSM stuck.
        default: begin
          ser_out   <= IDLE_LEVEL;
          ser_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serialiser.sv
// -----------------------------------------------------------------------------
// tb_piso_serialiser
// Two serialisers (MSB-first and LSB-first, WIDTH=8, idle level 1) driven
// with directed vectors. A bench model keeps, per instance, the ordered list
// of bits still to be presented; the outputs are compared with it on every
// falling edge. Directed checks pin the model with hand-computed literals.
// Honours PISO_PARITY_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_piso_serialiser;

  localparam int   WIDTH = 8;
  localparam logic IDLE  = 1'b1;
`ifdef PISO_PARITY_EN
  localparam int   NB    = WIDTH + 1;
`else
  localparam int   NB    = WIDTH;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             lv  [2];
  logic [WIDTH-1:0] ld  [2];
  logic             se  [2];
  logic             rdy [2];
  logic             so  [2];
  logic             sv  [2];
  logic             dn  [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  piso_serialiser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(rdy[0]),
    .load_data(ld[0]), .shift_en(se[0]), .ser_out(so[0]), .ser_valid(sv[0]),
    .done(dn[0])
  );

  piso_serialiser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(rdy[1]),
    .load_data(ld[1]), .shift_en(se[1]), .ser_out(so[1]), .ser_valid(sv[1]),
    .done(dn[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // m_bits[i][0] is the bit currently presented; m_n[i] bits remain.
  logic [NB-1:0] m_bits [2];
  int            m_n    [2];
  logic          m_done [2];
  logic          m_armed;

  function automatic logic [NB-1:0] bit_list(input logic [WIDTH-1:0] w, input bit msb);
    logic [NB-1:0] l;
    l = '0;
    for (int b = 0; b < WIDTH; b++) l[b] = msb ? w[WIDTH-1-b] : w[b];
`ifdef PISO_PARITY_EN
    l[WIDTH] = ^w;
`endif
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit was_armed;
    if (!rst_n) begin
      m_armed = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_bits[i] = '0;
        m_n[i]    = 0;
        m_done[i] = 1'b0;
      end
    end else begin
      was_armed = m_armed;
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 1'b0;
        if (m_n[i] > 0) begin
          if (se[i]) begin
            m_bits[i] = m_bits[i] >> 1;
            m_n[i]--;
            if (m_n[i] == 0) m_done[i] = 1'b1;
          end
        end else if (was_armed && lv[i]) begin
          m_bits[i] = bit_list(ld[i], (i == 0));
          m_n[i]    = NB;
        end
      end
      m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ser_valid[%0d]", i), sv[i], (m_n[i] > 0));
        check($sformatf("ser_out[%0d]", i), so[i], (m_n[i] > 0) ? m_bits[i][0] : IDLE);
        check($sformatf("done[%0d]", i), dn[i], m_done[i]);
        check($sformatf("load_ready[%0d]", i), rdy[i], m_armed && (m_n[i] == 0));
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0]  cap;
  logic              held;
  logic [2*NB-1:0]   stream;
  logic [2*NB-1:0]   stream_exp;
  int                nv;
  int                nd;

  initial begin
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0;
      ld[i] = '0;
      se[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_state", {rdy[0], sv[0], so[0], dn[0]}, 4'b0010);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("ready_after_first_release", rdy[0], 1'b1);

    // 0xA5 MSB-first, shift_en held high.
    se[0] = 1'b1; lv[0] = 1'b1; ld[0] = 8'hA5;
    tick();
    lv[0] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      cap[WIDTH-1-k] = so[0];
    end
`ifdef PISO_PARITY_EN
    @(negedge clk);
    check("a5_parity_bit", {sv[0], so[0]}, 2'b10);
`endif
    @(negedge clk);
    check("a5_done_ready_idle", {dn[0], rdy[0], so[0], sv[0]}, 4'b1110);
    check("a5_word", cap, 8'hA5);

    // 0x1E LSB-first: 0,1,1,1,1,0,0,0.
    se[1] = 1'b1; lv[1] = 1'b1; ld[1] = 8'h1E;
    tick();
    lv[1] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      cap[k] = so[1];
    end
`ifdef PISO_PARITY_EN
    @(negedge clk);
    check("1e_parity_bit", {sv[1], so[1]}, 2'b10);
`endif
    @(negedge clk);
    check("1e_done", {dn[1], rdy[1]}, 2'b11);
    check("1e_word", cap, 8'h1E);

    // 0x3C with shift_en toggling; 0xFF offered mid-word must be ignored.
    tick();
    se[0] = 1'b1; lv[0] = 1'b1; ld[0] = 8'h3C;
    tick();
    lv[0] = 1'b0;
    for (int j = 1; j <= 2*NB; j++) begin
      se[0] = (j % 2 == 0);
      lv[0] = (j == 5 || j == 6);
      ld[0] = (j == 5 || j == 6) ? 8'hFF : 8'h00;
      @(negedge clk);
      if (j % 2 == 1) begin
        held = so[0];
        if ((j - 1) / 2 < WIDTH) cap[WIDTH-1-(j-1)/2] = so[0];
      end else begin
        check("stall_hold", so[0], held);
      end
      tick();
    end
    lv[0] = 1'b0; se[0] = 1'b1;
    @(negedge clk);
    check("3c_done_after_stalls", dn[0], 1'b1);
    check("3c_word", cap, 8'h3C);

    // Back-to-back: 0x81, then 0x7E loaded in the done cycle.
    tick();
    lv[0] = 1'b1; ld[0] = 8'h81;
    tick();
    lv[0] = 1'b0;
    nv = 0; nd = 0; stream = '0;
    for (int j = 1; j <= 2*NB + 2; j++) begin
      lv[0] = (j == NB + 1);
      ld[0] = 8'h7E;
      @(negedge clk);
      if (sv[0]) begin
        stream = {stream[2*NB-2:0], so[0]};
        nv++;
      end
      if (dn[0]) nd++;
      if (j == NB + 2) check("b2b_second_word_immediate", sv[0], 1'b1);
      tick();
    end
    lv[0] = 1'b0;
`ifdef PISO_PARITY_EN
    stream_exp = {8'h81, 1'b0, 8'h7E, 1'b0};
`else
    stream_exp = 16'h817E;
`endif
    check("b2b_valid_bits", nv, 2*NB);
    check("b2b_done_pulses", nd, 2);
    check("b2b_stream", stream, stream_exp);

    // Reset after three bits of 0xF0.
    lv[0] = 1'b1; ld[0] = 8'hF0;
    tick();
    lv[0] = 1'b0;
    repeat (3) @(negedge clk);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", {sv[0], so[0], rdy[0], dn[0]}, 4'b0100);
    @(posedge clk);
    #3 rst_n = 1'b1;
    nd = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (dn[0]) nd++;
    end
    check("reset_no_done", nd, 0);
    check("ready_after_release", rdy[0], 1'b1);

    // 0x1F: parity bit is 1 when enabled.
    tick();
    lv[0] = 1'b1; ld[0] = 8'h1F;
    tick();
    lv[0] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      cap[WIDTH-1-k] = so[0];
    end
`ifdef PISO_PARITY_EN
    @(negedge clk);
    check("1f_parity_bit", {sv[0], so[0], dn[0]}, 3'b110);
`endif
    @(negedge clk);
    check("1f_done", dn[0], 1'b1);
    check("1f_word", cap, 8'h1F);

    // shift_en pulses while idle change nothing (model compares each cycle).
    se[1] = 1'b1;
    repeat (3) tick();
    se[1] = 1'b0;
    repeat (2) tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
